bayer_quad_router: RTL and testbench
====================================

BAYER_QUAD_ROUTER -- requirements
Module: bayer_quad_router

Interface
REQ-001 Parameter PIX_W, default 8, bits per pixel sample.
REQ-002 Parameter LINE_LEN, default 640, 2x2 windows per line (min 2).
REQ-003 Parameter NUM_LINES, default 480, lines per frame (min 2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pattern  input  2  sensor CFA at frame origin: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.
REQ-007 in_valid  input  1  input window valid.
REQ-008 in_ready  output  1  block accepts window this cycle.
REQ-009 in_sof  input  1  accompanies the first window of a frame.
REQ-010 wb_1..wb_4  input  PIX_W each  2x2 window samples: top-left, top-right, bottom-left, bottom-right.
REQ-011 out_valid  output  1  output word valid.
REQ-012 out_ready  input  1  downstream accepts output word.
REQ-013 out  output  4*PIX_W  {R, G1, G2, B}, R in the MSBs.
REQ-014 out_eol / out_eof  output  1 each  output word is last of line / last of frame.
REQ-015 sof_err  output  1  sticky flag: in_sof arrived with counters not at origin.

Function
REQ-016 Transfer on input occurs when in_valid and in_ready are both 1; transfer on output occurs when out_valid and out_ready are both 1.
REQ-017 Single output register; in_ready = !out_valid || out_ready (combinational); accepted window appears on out the next cycle (latency 1).
REQ-018 out, out_eol, out_eof SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Counters col (clog2(LINE_LEN) bits) and row (clog2(NUM_LINES) bits) SHALL advance only on input transfer.
REQ-020 On transfer, col increments; at col=LINE_LEN-1, col wraps to 0 and row increments; at row=NUM_LINES-1 with col=LINE_LEN-1, both wrap to 0.
REQ-021 A transfer with in_sof=1 SHALL be treated as position (0,0) regardless of counter values, and next position is (0,1).
REQ-022 If in_sof=1 on transfer while counters not at (0,0), sof_err SHALL be set; it is cleared only by rst.
REQ-023 Active pattern SHALL be latched from the pattern input on any transfer at position (0,0), including in_sof transfers, and held for the rest of the frame; mid-frame changes of pattern have no effect.
REQ-024 For the transfer at (0,0), the value of pattern sampled in that same cycle SHALL be used.
REQ-025 Phase = {row[0], col[0]} XOR active_pattern.
REQ-026 Phase 0: {R,G1,G2,B} = {wb_1,wb_2,wb_3,wb_4}.
REQ-027 Phase 1: R=wb_2, G1=wb_1, G2=wb_4, B=wb_3.
REQ-028 Phase 2: R=wb_3, G1=wb_1, G2=wb_4, B=wb_2.
REQ-029 Phase 3: R=wb_4, G1=wb_2, G2=wb_3, B=wb_1.
REQ-030 out_eol=1 for the word from col=LINE_LEN-1; out_eof=1 for the word from (NUM_LINES-1, LINE_LEN-1).
REQ-031 Simultaneous output transfer and input transfer in the same cycle SHALL replace the output word with no bubble, sustaining 1 word/cycle.
REQ-032 When in_valid=0, counters and active pattern SHALL hold; out_valid clears after an output transfer.

Reset
REQ-033 On rst: out_valid=0, out=0, out_eol=0, out_eof=0, sof_err=0, col=0, row=0, active_pattern=0.
REQ-034 in_ready SHALL be 1 during and immediately after reset.
REQ-035 Reset asserted mid-frame SHALL discard the held word; the next transfer after reset is position (0,0).

Verification
REQ-036 Test 1 -- PIX_W=8, pattern=0, in_sof with wb={11,22,33,44}, out_ready=1: out=0x11223344 one cycle later; next window {11,22,33,44} gives 0x22114433.
REQ-037 Test 2 -- pattern=3, first window {A1,B2,C3,D4}: out=0xD4B2C3A1; pattern changed to 0 mid-line leaves mapping unchanged until next (0,0).
REQ-038 Test 3 -- LINE_LEN=4, NUM_LINES=2, stream 8 windows: out_eol on words 4 and 8, out_eof on word 8 only; row-1 words use phase 2/3 mapping.
REQ-039 Test 4 -- hold out_ready=0 for 3 cycles with in_valid=1: in_ready=0, out stable, counters frozen; releasing out_ready resumes with no loss or duplication.
REQ-040 Test 5 -- in_sof at col=2: that window maps as phase pattern, next window as col=1, sof_err=1 and stays 1 until rst.
REQ-041 Test 6 -- assert rst with out_valid=1 at row 1: out_valid=0 immediately, sof_err=0; next transfer maps as (0,0).

Source files
------------

// File: rtl/bayer_quad_router_if.sv
// bayer_quad_router_if: input window and output word handshake bundle.
//   master drives in_valid/in_sof/wb_1..wb_4/out_ready and observes the rest;
//   slave (the router) drives in_ready/out_valid/out/out_eol/out_eof.
interface bayer_quad_router_if #(
    parameter int PIX_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic               in_sof;
    logic [PIX_W-1:0]   wb_1;
    logic [PIX_W-1:0]   wb_2;
    logic [PIX_W-1:0]   wb_3;
    logic [PIX_W-1:0]   wb_4;
    logic               out_valid;
    logic               out_ready;
    logic [4*PIX_W-1:0] out;
    logic               out_eol;
    logic               out_eof;

    modport master (
        output in_valid, in_sof, wb_1, wb_2, wb_3, wb_4, out_ready,
        input  in_ready, out_valid, out, out_eol, out_eof
    );

    modport slave (
        input  in_valid, in_sof, wb_1, wb_2, wb_3, wb_4, out_ready,
        output in_ready, out_valid, out, out_eol, out_eof
    );
endinterface

// File: rtl/bayer_quad_router.sv
// bayer_quad_router: reorders 2x2 Bayer windows into {R,G1,G2,B} words.
//   clk, rst  : clock, asynchronous active-high reset
//   pattern   : CFA layout at frame origin (0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR)
//   sof_err   : sticky, in_sof seen while counters were away from origin
//   bus       : window input / word output handshake (slave side)
module bayer_quad_router #(
    parameter int PIX_W     = 8,
    parameter int LINE_LEN  = 640,
    parameter int NUM_LINES = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           pattern,
    output logic                 sof_err,
    bayer_quad_router_if.slave   bus
);
    localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int RW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    logic [CW-1:0]      col, col_n, ecol;
    logic [RW-1:0]      row, row_n, erow;
    logic [1:0]         act_pat, use_pat, phase;
    logic               origin, last_col, last_row, in_xfer;
    logic [4*PIX_W-1:0] mapped;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign in_xfer      = bus.in_valid && bus.in_ready;

    // in_sof forces the window to the origin whatever the counters say
    always_comb begin
        ecol     = bus.in_sof ? '0 : col;
        erow     = bus.in_sof ? '0 : row;
        origin   = (ecol == '0) && (erow == '0);
        use_pat  = origin ? pattern : act_pat;
        phase    = {erow[0], ecol[0]} ^ use_pat;
        last_col = ecol == CW'(LINE_LEN - 1);
        last_row = erow == RW'(NUM_LINES - 1);
        col_n    = last_col ? '0 : ecol + 1'b1;
        row_n    = !last_col ? erow : (last_row ? '0 : erow + 1'b1);
        mapped   = (phase == 2'd0) ? {bus.wb_1, bus.wb_2, bus.wb_3, bus.wb_4} :
                   (phase == 2'd1) ? {bus.wb_2, bus.wb_1, bus.wb_4, bus.wb_3} :
                   (phase == 2'd2) ? {bus.wb_3, bus.wb_1, bus.wb_4, bus.wb_2} :
                                     {bus.wb_4, bus.wb_2, bus.wb_3, bus.wb_1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col           <= '0;
            row           <= '0;
            act_pat       <= '0;
            sof_err       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.out_eol   <= 1'b0;
            bus.out_eof   <= 1'b0;
        end else begin
            bus.out_valid <= in_xfer || (bus.out_valid && !bus.out_ready);
            if (in_xfer) begin
                col         <= col_n;
                row         <= row_n;
                act_pat     <= use_pat;
                bus.out     <= mapped;
                bus.out_eol <= last_col;
                bus.out_eof <= last_col && last_row;
                if (bus.in_sof && (col != '0 || row != '0))
                    sof_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bayer_quad_router.sv
// tb_bayer_quad_router: directed checks of the Bayer window router.
module tb_bayer_quad_router;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] pattern = 2'd0;
    logic       sof_err;
    int         tests = 0;
    int         fails = 0;

    bayer_quad_router_if #(.PIX_W(8)) bus ();

    bayer_quad_router #(.PIX_W(8), .LINE_LEN(4), .NUM_LINES(2)) dut (
        .clk(clk), .rst(rst), .pattern(pattern), .sof_err(sof_err), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic sof, input logic [7:0] a, b, c, d);
        @(negedge clk);
        bus.in_sof   = sof;
        bus.wb_1     = a;
        bus.wb_2     = b;
        bus.wb_3     = c;
        bus.wb_4     = d;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({bus.out_valid, bus.out_eol, bus.out_eof, sof_err, bus.out} !== 36'h0) begin
            fails++;
            $display("FAIL reset_state: got v=%b eol=%b eof=%b err=%b out=%h, expected all zero",
                     bus.out_valid, bus.out_eol, bus.out_eof, sof_err, bus.out);
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        pattern = 2'd0;
        send(1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
        tests++;
        if ({bus.out_valid, bus.out} !== {1'b1, 32'h11223344}) begin
            fails++;
            $display("FAIL basic_w0: got v=%b out=%h expected v=1 out=11223344", bus.out_valid, bus.out);
        end
        send(1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        tests++;
        if ({bus.out_valid, bus.out} !== {1'b1, 32'h22114433}) begin
            fails++;
            $display("FAIL basic_w1: got v=%b out=%h expected v=1 out=22114433", bus.out_valid, bus.out);
        end
        idle();
        @(posedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_drain: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_pattern_latch();
        logic [31:0] exp_out [9];
        exp_out = '{32'hD4B2C3A1, 32'hC3A1D4B2, 32'hD4B2C3A1, 32'hC3A1D4B2,
                    32'hB2A1D4C3, 32'hA1B2C3D4, 32'hB2A1D4C3, 32'hA1B2C3D4,
                    32'hA1B2C3D4};
        apply_reset();
        pattern = 2'd3;
        for (int i = 0; i < 9; i++) begin
            send(i == 0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
            if (i == 0) pattern = 2'd0;
            tests++;
            if ({bus.out_eol, bus.out_eof, bus.out} !== {i == 3 || i == 7, i == 7, exp_out[i]}) begin
                fails++;
                $display("FAIL pattern_w%0d: got eol=%b eof=%b out=%h expected eol=%b eof=%b out=%h",
                         i, bus.out_eol, bus.out_eof, bus.out, i == 3 || i == 7, i == 7, exp_out[i]);
            end
        end
        idle();
    endtask

    task automatic test_frame();
        logic [31:0] exp_out [8];
        exp_out = '{32'h01020304, 32'h02010403, 32'h01020304, 32'h02010403,
                    32'h03010402, 32'h04020301, 32'h03010402, 32'h04020301};
        apply_reset();
        pattern = 2'd0;
        for (int i = 0; i < 8; i++) begin
            send(i == 0, 8'h01, 8'h02, 8'h03, 8'h04);
            tests++;
            if ({bus.out_valid, bus.out_eol, bus.out_eof, bus.out} !==
                {1'b1, i == 3 || i == 7, i == 7, exp_out[i]}) begin
                fails++;
                $display("FAIL frame_w%0d: got v=%b eol=%b eof=%b out=%h expected v=1 eol=%b eof=%b out=%h",
                         i, bus.out_valid, bus.out_eol, bus.out_eof, bus.out, i == 3 || i == 7, i == 7, exp_out[i]);
            end
        end
        idle();
    endtask

    task automatic test_backpressure();
        apply_reset();
        pattern = 2'd0;
        send(1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_sof    = 1'b0;
        bus.wb_1      = 8'h55;
        bus.wb_2      = 8'h66;
        bus.wb_3      = 8'h77;
        bus.wb_4      = 8'h88;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({bus.out_valid, bus.out_eol, bus.out} !== {1'b1, 1'b0, 32'h11223344}) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b eol=%b out=%h expected v=1 eol=0 out=11223344",
                         i, bus.out_valid, bus.out_eol, bus.out);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({bus.out_valid, bus.out_eol, bus.out} !== {1'b1, 1'b0, 32'h66558877}) begin
            fails++;
            $display("FAIL bp_resume_w1: got v=%b eol=%b out=%h expected v=1 eol=0 out=66558877",
                     bus.out_valid, bus.out_eol, bus.out);
        end
        send(1'b0, 8'h55, 8'h66, 8'h77, 8'h88);
        tests++;
        if ({bus.out_eol, bus.out} !== {1'b0, 32'h55667788}) begin
            fails++;
            $display("FAIL bp_resume_w2: got eol=%b out=%h expected eol=0 out=55667788", bus.out_eol, bus.out);
        end
        send(1'b0, 8'h55, 8'h66, 8'h77, 8'h88);
        tests++;
        if ({bus.out_eol, bus.out} !== {1'b1, 32'h66558877}) begin
            fails++;
            $display("FAIL bp_resume_w3: got eol=%b out=%h expected eol=1 out=66558877", bus.out_eol, bus.out);
        end
        idle();
    endtask

    task automatic test_sof_err();
        apply_reset();
        pattern = 2'd0;
        send(1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
        send(1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
        tests++;
        if (sof_err !== 1'b0) begin
            fails++;
            $display("FAIL sof_err_clean: got %b expected 0", sof_err);
        end
        pattern = 2'd2;
        send(1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
        tests++;
        if ({sof_err, bus.out_eol, bus.out} !== {1'b1, 1'b0, 32'h03010402}) begin
            fails++;
            $display("FAIL sof_err_resync: got err=%b eol=%b out=%h expected err=1 eol=0 out=03010402",
                     sof_err, bus.out_eol, bus.out);
        end
        send(1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
        tests++;
        if ({bus.out_eol, bus.out} !== {1'b0, 32'h04020301}) begin
            fails++;
            $display("FAIL sof_err_next: got eol=%b out=%h expected eol=0 out=04020301", bus.out_eol, bus.out);
        end
        send(1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
        send(1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
        tests++;
        if ({bus.out_eol, bus.out} !== {1'b1, 32'h04020301}) begin
            fails++;
            $display("FAIL sof_err_eol: got eol=%b out=%h expected eol=1 out=04020301", bus.out_eol, bus.out);
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sof_err !== 1'b1) begin
            fails++;
            $display("FAIL sof_err_sticky: got %b expected 1", sof_err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
        tests++;
        if ({bus.out_valid, bus.out} !== {1'b1, 32'h01020304}) begin
            fails++;
            $display("FAIL mid_row1_word: got v=%b out=%h expected v=1 out=01020304", bus.out_valid, bus.out);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.out_valid, sof_err, bus.out_eol, bus.out_eof, bus.out, bus.in_ready} !== {36'h0, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset: got v=%b err=%b eol=%b eof=%b out=%h rdy=%b expected zeros with rdy=1",
                     bus.out_valid, sof_err, bus.out_eol, bus.out_eof, bus.out, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        pattern = 2'd3;
        send(1'b0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        tests++;
        if ({bus.out_valid, bus.out} !== {1'b1, 32'hD4B2C3A1}) begin
            fails++;
            $display("FAIL mid_after_reset: got v=%b out=%h expected v=1 out=D4B2C3A1", bus.out_valid, bus.out);
        end
        idle();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.wb_1      = '0;
        bus.wb_2      = '0;
        bus.wb_3      = '0;
        bus.wb_4      = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_pattern_latch();
        test_frame();
        test_backpressure();
        test_sof_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
